// File: rtl/data_memory_unit_if.sv
// rtl/data_memory_unit_if.sv - core-to-data-memory load/store bus
interface data_memory_unit_if;
    logic        r_enable;
    logic        w_enable;
    logic [31:0] address;
    logic [2:0]  rw_type;
    logic [31:0] mem_datain;
    logic [31:0] RD_data;

    modport master (
        output r_enable, w_enable, address, rw_type, mem_datain,
        input  RD_data
    );

    modport slave (
        input  r_enable, w_enable, address, rw_type, mem_datain,
        output RD_data
    );
endinterface

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - single-cycle data RAM with LED, cycle counter and sticky error MMIO
module data_memory_unit #(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_unit_if.slave    bus,
    output logic [7:0]           led,
    output logic                 err
);
    localparam int          DEPTH     = 1 << ADDR_W;
    localparam logic [31:0] ADDR_LED  = 32'h8000_0000;
    localparam logic [31:0] ADDR_CYC  = 32'h8000_0004;
    localparam logic [31:0] ADDR_ERR  = 32'h8000_0008;

    logic [31:0] r_mem [DEPTH];
    logic [7:0]  r_led;
    logic [31:0] r_cycle;
    logic        r_err;

    logic              w_is_ram;
    logic              w_is_led;
    logic              w_is_cyc;
    logic              w_is_errreg;
    logic              w_is_mmio;
    logic              w_type_ok;
    logic              w_misalign;
    logic              w_acc_err;
    logic              w_err_evt;
    logic              w_wr_ok;
    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_ofs;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rword;
    logic [31:0]       w_shift;
    logic [15:0]       w_half;
    logic [31:0]       w_rdata;

    assign w_idx       = bus.address[ADDR_W+1:2];
    assign w_ofs       = bus.address[1:0];
    assign w_is_ram    = (bus.address[31:ADDR_W+2] == '0);
    assign w_is_led    = (bus.address == ADDR_LED);
    assign w_is_cyc    = (bus.address == ADDR_CYC);
    assign w_is_errreg = (bus.address == ADDR_ERR);
    assign w_is_mmio   = w_is_led | w_is_cyc | w_is_errreg;

    always_comb begin
        w_type_ok = 1'b0;
        case (bus.rw_type)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_type_ok = 1'b1;
            default:                                w_type_ok = 1'b0;
        endcase
    end

    // rw_type[1:0] gives the access size for every legal encoding
    assign w_misalign = ((bus.rw_type[1:0] == 2'b01) && w_ofs[0]) ||
                        ((bus.rw_type[1:0] == 2'b10) && (w_ofs != 2'b00));
    assign w_acc_err  = !w_type_ok || w_misalign || !(w_is_ram || w_is_mmio) ||
                        (w_is_mmio && (bus.rw_type != 3'b010));
    assign w_err_evt  = (bus.r_enable || bus.w_enable) && w_acc_err;
    assign w_wr_ok    = bus.w_enable && !w_acc_err;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (bus.rw_type[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_ofs;
                w_wdata = {4{bus.mem_datain[7:0]}};
            end
            2'b01: begin
                w_be    = w_ofs[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.mem_datain[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.mem_datain;
            end
        endcase
    end

    // RAM has no reset: a store that reaches an edge commits even while reset is low
    always_ff @(posedge clk) begin
        if (w_wr_ok && w_is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led   <= 8'h00;
            r_cycle <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_wr_ok && w_is_led) begin
                r_led <= bus.mem_datain[7:0];
            end
            if (w_wr_ok && w_is_cyc) begin
                r_cycle <= bus.mem_datain;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
            // a new error outranks a clear issued in the same cycle
            if (w_err_evt) begin
                r_err <= 1'b1;
            end else if (w_wr_ok && w_is_errreg && bus.mem_datain[0]) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rword = 32'h0;
        if (w_is_ram) begin
            w_rword = r_mem[w_idx];
        end else if (w_is_led) begin
            w_rword = {24'h0, r_led};
        end else if (w_is_cyc) begin
            w_rword = r_cycle;
        end else if (w_is_errreg) begin
            w_rword = {31'h0, r_err};
        end
    end

    assign w_shift = w_rword >> {w_ofs, 3'b000};
    assign w_half  = w_ofs[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_rdata = w_rword;
        case (bus.rw_type)
            3'b000:  w_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_rdata = {24'h0, w_shift[7:0]};
            3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
            3'b101:  w_rdata = {16'h0, w_half};
            default: w_rdata = w_rword;
        endcase
    end

    assign bus.RD_data = (bus.r_enable && !w_acc_err) ? w_rdata : 32'h0;
    assign led         = r_led;
    assign err         = r_err;
endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - randomized bench for data_memory_unit against a byte-level reference model
module tb_data_memory_unit;
    localparam int          ADDR_W    = 8;
    localparam int          RAM_BYTES = 4 << ADDR_W;
    localparam logic [2:0]  T_B  = 3'd0, T_H = 3'd1, T_W = 3'd2, T_BU = 3'd4, T_HU = 3'd5;
    localparam logic [31:0] A_LED = 32'h8000_0000;
    localparam logic [31:0] A_CYC = 32'h8000_0004;
    localparam logic [31:0] A_ERR = 32'h8000_0008;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] led;
    logic       err;

    data_memory_unit_if bus_if();

    data_memory_unit #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .led   (led),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_ram [RAM_BYTES];
    logic [7:0]  m_led;
    logic        m_err;
    logic [31:0] m_cycle;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void classify(input logic [31:0] a, input logic [2:0] t,
                                     output bit bad, output int size, output bit sgn);
        bit in_ram;
        bit in_mmio;
        size = 0;
        sgn  = 1'b0;
        case (t)
            T_B:     begin size = 1; sgn = 1'b1; end
            T_H:     begin size = 2; sgn = 1'b1; end
            T_W:     size = 4;
            T_BU:    size = 1;
            T_HU:    size = 2;
            default: size = 0;
        endcase
        in_ram  = (a < RAM_BYTES);
        in_mmio = (a == A_LED) || (a == A_CYC) || (a == A_ERR);
        if (size == 0) bad = 1'b1;
        else bad = ((a % 32'(size)) != 0) || !(in_ram || in_mmio) || (in_mmio && size != 4);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] t);
        bit          bad;
        int          size;
        bit          sgn;
        logic [31:0] v;
        classify(a, t, bad, size, sgn);
        if (bad) return 32'h0;
        v = 32'h0;
        if (a < RAM_BYTES) begin
            for (int k = 0; k < size; k++) v |= 32'(m_ram[a + k]) << (8 * k);
        end else if (a == A_LED) v = {24'h0, m_led};
        else if (a == A_CYC) v = m_cycle;
        else v = {31'h0, m_err};
        if (sgn && size < 4 && v[8*size-1]) v |= ~((32'h1 << (8 * size)) - 32'h1);
        return v;
    endfunction

    function automatic void ref_edge(input bit re, input bit we, input logic [31:0] a,
                                     input logic [2:0] t, input logic [31:0] d);
        bit bad;
        int size;
        bit sgn;
        bit cyc_loaded;
        classify(a, t, bad, size, sgn);
        cyc_loaded = 1'b0;
        if (bad) begin
            if (re || we) m_err = 1'b1;
        end else if (we) begin
            if (a < RAM_BYTES) begin
                for (int k = 0; k < size; k++) m_ram[a + k] = 8'(d >> (8 * k));
            end else if (a == A_LED) m_led = d[7:0];
            else if (a == A_CYC) begin
                m_cycle    = d;
                cyc_loaded = 1'b1;
            end else if (d[0]) m_err = 1'b0;
        end
        if (!cyc_loaded) m_cycle = m_cycle + 32'd1;
    endfunction

    task automatic acc(input bit re, input bit we, input logic [31:0] a, input logic [2:0] t,
                       input logic [31:0] d, output logic [31:0] rd);
        logic [31:0] exp;
        @(negedge clk);
        bus_if.r_enable   = re;
        bus_if.w_enable   = we;
        bus_if.address    = a;
        bus_if.rw_type    = t;
        bus_if.mem_datain = d;
        #1;
        rd  = bus_if.RD_data;
        exp = re ? ref_load(a, t) : 32'h0;
        check_eq($sformatf("rd_data a=%h t=%0d re=%0d we=%0d", a, t, re, we), rd, exp);
        @(posedge clk);
        ref_edge(re, we, a, t, d);
        #1;
        check_eq($sformatf("led after a=%h", a), {24'h0, led}, {24'h0, m_led});
        check_eq($sformatf("err after a=%h t=%0d", a, t), {31'h0, err}, {31'h0, m_err});
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset             = 1'b0;
        bus_if.r_enable   = 1'b1;
        bus_if.w_enable   = 1'b0;
        bus_if.address    = A_CYC;
        bus_if.rw_type    = T_W;
        bus_if.mem_datain = 32'h0;
        #1;
        check_eq("reset_led", {24'h0, led}, 32'h0);
        check_eq("reset_err", {31'h0, err}, 32'h0);
        check_eq("reset_cycle_read", bus_if.RD_data, 32'h0);
        #1;
        reset           = 1'b1;
        bus_if.r_enable = 1'b0;
        m_led   = 8'h00;
        m_err   = 1'b0;
        m_cycle = 32'h0;
        @(posedge clk);
        ref_edge(1'b0, 1'b0, A_CYC, T_W, 32'h0);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [2:0]  t;
        bus_if.r_enable   = 1'b0;
        bus_if.w_enable   = 1'b0;
        bus_if.address    = 32'h0;
        bus_if.rw_type    = T_W;
        bus_if.mem_datain = 32'h0;
        #2 reset = 1'b0;

        pulse_reset();
        repeat (4) acc(1'b0, 1'b0, 32'h0, T_W, 32'h0, rd);
        acc(1'b1, 1'b0, A_CYC, T_W, 32'h0, rd);
        check_eq("cycle_5_after_release", rd, 32'd5);

        for (int i = 0; i < (1 << ADDR_W); i++) acc(1'b0, 1'b1, 32'(i * 4), T_W, $urandom, rd);

        acc(1'b0, 1'b1, 32'h10, T_W, 32'hDEADBEEF, rd);
        acc(1'b1, 1'b0, 32'h10, T_W, 32'h0, rd);
        check_eq("lw_0x10", rd, 32'hDEADBEEF);
        acc(1'b0, 1'b1, 32'h14, T_W, 32'h0, rd);
        acc(1'b1, 1'b0, 32'h14, T_W, 32'h0, rd);
        check_eq("lw_0x14", rd, 32'h0);

        acc(1'b0, 1'b1, 32'h20, T_W, 32'h11223344, rd);
        acc(1'b0, 1'b1, 32'h21, T_B, 32'h00000080, rd);
        acc(1'b1, 1'b0, 32'h20, T_W, 32'h0, rd);
        check_eq("lw_after_sb", rd, 32'h11228044);
        acc(1'b1, 1'b0, 32'h21, T_B, 32'h0, rd);
        check_eq("lb_sign", rd, 32'hFFFFFF80);
        acc(1'b1, 1'b0, 32'h21, T_BU, 32'h0, rd);
        check_eq("lbu_zero", rd, 32'h00000080);
        acc(1'b0, 1'b1, 32'h22, T_H, 32'h0000F00F, rd);
        acc(1'b1, 1'b0, 32'h22, T_H, 32'h0, rd);
        check_eq("lh_sign", rd, 32'hFFFFF00F);
        acc(1'b1, 1'b0, 32'h22, T_HU, 32'h0, rd);
        check_eq("lhu_zero", rd, 32'h0000F00F);

        acc(1'b1, 1'b0, 32'h21, T_H, 32'h0, rd);
        check_eq("lh_misaligned_rd", rd, 32'h0);
        check_eq("lh_misaligned_err", {31'h0, err}, 32'h1);
        acc(1'b0, 1'b1, 32'h24, T_W, 32'h5A5A1234, rd);
        acc(1'b1, 1'b0, 32'h24, T_W, 32'h0, rd);
        check_eq("sw_after_error", rd, 32'h5A5A1234);
        acc(1'b0, 1'b1, A_ERR, T_W, 32'h1, rd);
        check_eq("err_cleared", {31'h0, err}, 32'h0);

        acc(1'b0, 1'b1, A_LED, T_W, 32'h000001A5, rd);
        check_eq("led_write", {24'h0, led}, 32'hA5);
        acc(1'b1, 1'b0, A_LED, T_W, 32'h0, rd);
        check_eq("led_read", rd, 32'h000000A5);
        acc(1'b0, 1'b1, A_LED, T_B, 32'h00000077, rd);
        check_eq("led_sb_err", {31'h0, err}, 32'h1);
        check_eq("led_sb_unchanged", {24'h0, led}, 32'hA5);
        acc(1'b0, 1'b1, A_ERR, T_W, 32'h1, rd);
        acc(1'b1, 1'b0, 32'h4000_0000, T_W, 32'h0, rd);
        check_eq("unmapped_rd", rd, 32'h0);
        check_eq("unmapped_err", {31'h0, err}, 32'h1);

        acc(1'b0, 1'b1, A_CYC, T_W, 32'hFFFF_FFFE, rd);
        acc(1'b1, 1'b0, A_CYC, T_W, 32'h0, rd);
        check_eq("cycle_load", rd, 32'hFFFF_FFFE);
        acc(1'b1, 1'b0, A_CYC, T_W, 32'h0, rd);
        check_eq("cycle_max", rd, 32'hFFFF_FFFF);
        acc(1'b1, 1'b0, A_CYC, T_W, 32'h0, rd);
        check_eq("cycle_wrap", rd, 32'h0);

        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, RAM_BYTES - 1));
                6:                a = A_LED;
                7:                a = A_CYC;
                8:                a = A_ERR;
                default:          a = ($urandom_range(0, 1) == 0) ? 32'h8000_000C
                                      : {1'b0, 3'($urandom_range(1, 7)), 28'($urandom)};
            endcase
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0:       t = T_B;
                    1:       t = T_H;
                    2:       t = T_W;
                    3:       t = T_BU;
                    default: t = T_HU;
                endcase
            end else begin
                t = 3'($urandom_range(0, 7));
            end
            acc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, t, $urandom, rd);
        end

        acc(1'b0, 1'b1, A_LED, T_W, 32'h3C, rd);
        acc(1'b0, 1'b1, A_CYC, T_W, 32'd100, rd);
        acc(1'b0, 1'b1, 32'h40, T_W, 32'hCAFE0001, rd);
        acc(1'b1, 1'b0, 32'h3, T_H, 32'h0, rd);
        check_eq("pre_reset_led", {24'h0, led}, 32'h3C);
        check_eq("pre_reset_err", {31'h0, err}, 32'h1);
        pulse_reset();
        acc(1'b1, 1'b0, 32'h40, T_W, 32'h0, rd);
        check_eq("ram_survives_reset", rd, 32'hCAFE0001);
        acc(1'b1, 1'b0, A_CYC, T_W, 32'h0, rd);
        check_eq("cycle_after_reset", rd, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
